alu_operand_stage: RTL and testbench

//  Execute-stage front end. Sits directly upstream of the ALU.

---
 rtl/alu_operand_stage_pkg.sv | 55 +++++
 rtl/alu_operand_slot.sv | 57 +++++
 rtl/alu_operand_stage.sv | 150 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_stage_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_operand_stage_pkg
// Purpose  : Shared widths, ALU function encodings, stage FSM states, the
//            held-entry record and the funct_alu forming helper for the
//            ALU operand stage.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_operand_stage_pkg;

  localparam int XLEN    = 32;
  localparam int REGADDR = 5;

  // ALU function encodings: {funct7[5], funct3}
  localparam logic [3:0] FUNCT_ALU_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_ALU_SUB = 4'b1000;
  localparam logic [3:0] FUNCT_ALU_SRL = 4'b0101;
  localparam logic [3:0] FUNCT_ALU_SRA = 4'b1101;

  // Stage occupancy: EMPTY (nothing held), BUSY (main only), FULL (main+skid)
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // One held instruction. The source addresses and flags travel with the
  // operands so a held entry can still pick up a later writeback.
  typedef struct packed {
    logic [XLEN-1:0]    op1;
    logic [XLEN-1:0]    op2;
    logic [3:0]         funct_alu;
    logic [REGADDR-1:0] rd_addr;
    logic [REGADDR-1:0] rs1_addr;
    logic [REGADDR-1:0] rs2_addr;
    logic               src1_pc;
    logic               src2_imm;
  } slot_t;

  // Bit 3 comes from instr[30] for register-register ops and for the
  // right-shift group (SRLI/SRAI). For every other OP-IMM, instr[30] is an
  // immediate bit, so it must be masked or ADDI would turn into SUB.
  function automatic logic [3:0] form_funct_alu(input logic [2:0] funct3,
                                                input logic       funct7b5,
                                                input logic       is_opimm);
    logic bit3;
    bit3 = funct7b5 & (~is_opimm | (funct3 == FUNCT_ALU_SRL[2:0]));
    return {bit3, funct3};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_operand_slot.sv
//------------------------------------------------------------------------------
// Module   : alu_operand_slot
// Purpose  : One held-instruction register (operands, funct_alu, rd, source
//            addresses and flags) with optional writeback forwarding applied
//            both to a newly loaded entry and to the entry while it is held.
// Config   : `ALU_OPERAND_FWD_EN enables forwarding; when undefined the wb_*
//            inputs are ignored and no compare logic exists.
// Ports    : clk, rst_n      - clock, async active-low reset
//            load           - capture d this cycle, else keep the held entry
//            d              - entry to capture
//            wb_we/wb_rd_addr/wb_data - writeback bus
//            q              - held entry
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_operand_slot
  import alu_operand_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  slot_t              d,
  input  logic               wb_we,
  input  logic [REGADDR-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]    wb_data,
  output slot_t              q
);

  slot_t src;
  slot_t nxt;

  always_comb begin
    src = load ? d : q;
    nxt = src;
`ifdef ALU_OPERAND_FWD_EN
    // x0 is never a forwarding source; pc/imm operands are never replaced.
    if (wb_we && (wb_rd_addr != '0)) begin
      if (!src.src1_pc && (src.rs1_addr == wb_rd_addr)) nxt.op1 = wb_data;
      if (!src.src2_imm && (src.rs2_addr == wb_rd_addr)) nxt.op2 = wb_data;
    end
`endif
  end

`ifndef ALU_OPERAND_FWD_EN
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd_addr, wb_data};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= nxt;
  end

endmodule

`default_nettype wire

// File: rtl/alu_operand_stage.sv
//------------------------------------------------------------------------------
// Module   : alu_operand_stage
// Purpose  : Execute-stage front end ahead of the ALU. Accepts decoded
//            instructions over valid/ready, selects rs1/pc and rs2/imm,
//            forms funct_alu and holds the result in a main register backed
//            by a skid register so in_ready can be registered.
// Config   : `ALU_OPERAND_FWD_EN enables writeback forwarding into captured
//            and held register-sourced operands.
// Ports    : clk, rst_n, flush          - clock, async reset, sync kill
//            in_valid/in_ready, in_*     - decode side handshake and fields
//            wb_we/wb_rd_addr/wb_data    - writeback bus
//            out_valid/out_ready         - ALU side handshake
//            aluin1, aluin2, funct_alu, out_rd_addr - ALU side payload
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_operand_stage
  import alu_operand_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [REGADDR-1:0] in_rs1_addr,
  input  logic [REGADDR-1:0] in_rs2_addr,
  input  logic [REGADDR-1:0] in_rd_addr,
  input  logic [2:0]         in_funct3,
  input  logic               in_funct7b5,
  input  logic               in_src1_pc,
  input  logic               in_src2_imm,
  input  logic               in_is_opimm,
  input  logic               wb_we,
  input  logic [REGADDR-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]    wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    aluin1,
  output logic [XLEN-1:0]    aluin2,
  output logic [3:0]         funct_alu,
  output logic [REGADDR-1:0] out_rd_addr
);

  state_t state, state_d;
  slot_t  in_entry, main_d, main_q, skid_q;
  logic   main_load, main_from_skid, skid_load;
  logic   in_xfer, out_xfer;

  // Both handshake outputs decode straight from the state register.
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    in_entry.op1       = in_src1_pc  ? in_pc  : in_rs1_data;
    in_entry.op2       = in_src2_imm ? in_imm : in_rs2_data;
    in_entry.funct_alu = form_funct_alu(in_funct3, in_funct7b5, in_is_opimm);
    in_entry.rd_addr   = in_rd_addr;
    in_entry.rs1_addr  = in_rs1_addr;
    in_entry.rs2_addr  = in_rs2_addr;
    in_entry.src1_pc   = in_src1_pc;
    in_entry.src2_imm  = in_src2_imm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_d;
  end

  always_comb begin
    state_d        = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      // Flush beats any transfer: held entries and a coincident input die.
      state_d = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d   = ST_BUSY;
            main_load = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end else if (in_xfer) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            state_d        = ST_BUSY;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_entry;

  alu_operand_slot u_main (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (main_load),
    .d          (main_d),
    .wb_we      (wb_we),
    .wb_rd_addr (wb_rd_addr),
    .wb_data    (wb_data),
    .q          (main_q)
  );

  alu_operand_slot u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .d          (in_entry),
    .wb_we      (wb_we),
    .wb_rd_addr (wb_rd_addr),
    .wb_data    (wb_data),
    .q          (skid_q)
  );

  assign aluin1      = main_q.op1;
  assign aluin2      = main_q.op2;
  assign funct_alu   = main_q.funct_alu;
  assign out_rd_addr = main_q.rd_addr;

  // Source bookkeeping of the main entry only matters inside the slot.
  logic unused_main;
  assign unused_main = ^{main_q.rs1_addr, main_q.rs2_addr,
                         main_q.src1_pc, main_q.src2_imm};

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none

module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
  logic [4:0]  in_rs1_addr = '0, in_rs2_addr = '0, in_rd_addr = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_funct7b5 = 1'b0, in_src1_pc = 1'b0, in_src2_imm = 1'b0;
  logic        in_is_opimm = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] aluin1, aluin2;
  logic [3:0]  funct_alu;
  logic [4:0]  out_rd_addr;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rd_addr(in_rd_addr), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_src1_pc(in_src1_pc), .in_src2_imm(in_src2_imm), .in_is_opimm(in_is_opimm),
    .wb_we(wb_we), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluin1(aluin1), .aluin2(aluin2), .funct_alu(funct_alu),
    .out_rd_addr(out_rd_addr)
  );

  typedef struct {
    logic [31:0] a1;
    logic [31:0] a2;
    logic [3:0]  f;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference model of one accepted instruction.
  function automatic exp_t model();
    exp_t e;
    logic b3;
    b3   = in_funct7b5 && (!in_is_opimm || in_funct3 == 3'b101);
    e.a1 = in_src1_pc  ? in_pc  : in_rs1_data;
    e.a2 = in_src2_imm ? in_imm : in_rs2_data;
    e.f  = {b3, in_funct3};
    e.rd = in_rd_addr;
    return e;
  endfunction

  // Scoreboard: at the negedge, inputs are settled for the coming posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("aluin1", aluin1, e.a1);
            check("aluin2", aluin2, e.a2);
            check("funct_alu", {28'd0, funct_alu}, {28'd0, e.f});
            check("rd", {27'd0, out_rd_addr}, {27'd0, e.rd});
          end
        end
        if (in_valid && in_ready) sb.push_back(model());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] r1d, input logic [31:0] r2d,
                      input logic [31:0] imm, input logic [4:0] r1a, input logic [4:0] r2a,
                      input logic [4:0] rd, input logic [2:0] f3, input logic f7,
                      input logic s1pc, input logic s2imm, input logic opimm);
    in_pc = pc; in_rs1_data = r1d; in_rs2_data = r2d; in_imm = imm;
    in_rs1_addr = r1a; in_rs2_addr = r2a; in_rd_addr = rd;
    in_funct3 = f3; in_funct7b5 = f7; in_src1_pc = s1pc; in_src2_imm = s2imm;
    in_is_opimm = opimm;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    out_ready = 1'b1;
    for (int i = 0; i < budget && (sb.size() != 0 || out_valid); i++) step();
    check("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_aluin1", aluin1, 32'd0);
    check("rst_aluin2", aluin2, 32'd0);
    check("rst_funct", {28'd0, funct_alu}, 32'd0);
    check("rst_rd", {27'd0, out_rd_addr}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1. ADD, one-cycle latency
    out_ready = 1'b1;
    send(32'h100, 32'h17, 32'h0A, 32'h0, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("add_latency_valid", {31'd0, out_valid}, 32'd1);
    check("add_funct", {28'd0, funct_alu}, 32'h0);
    step();

    // 2. Back-to-back mix: ADDI, SRAI, SUB, SRLI, AUIPC, ANDI with bit30 set
    send(32'h104, 32'h5, 32'h9, 32'h400, 5'd4, 5'd6, 5'd7, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1);
    check("addi_funct", {28'd0, funct_alu}, 32'h0);
    check("addi_aluin2", aluin2, 32'h400);
    send(32'h108, 32'h80000000, 32'h0, 32'h403, 5'd8, 5'd0, 5'd9, 3'b101, 1'b1, 1'b0, 1'b1, 1'b1);
    check("srai_funct", {28'd0, funct_alu}, 32'hD);
    send(32'h10C, 32'h30, 32'h10, 32'h0, 5'd10, 5'd11, 5'd12, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sub_funct", {28'd0, funct_alu}, 32'h8);
    send(32'h110, 32'h7, 32'h0, 32'h2, 5'd13, 5'd0, 5'd14, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1);
    send(32'h114, 32'hAA, 32'hBB, 32'h12345000, 5'd0, 5'd0, 5'd15, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    check("auipc_aluin1", aluin1, 32'h114);
    send(32'h118, 32'hF0F0, 32'h1, 32'hFFFFFC0F, 5'd16, 5'd0, 5'd17, 3'b111, 1'b1, 1'b0, 1'b1, 1'b1);
    check("andi_funct", {28'd0, funct_alu}, 32'h7);
    drain(10);

    // 3. Backpressure: two back-to-back while stalled fill main and skid
    out_ready = 1'b0;
    send(32'h200, 32'h11, 32'h22, 32'h0, 5'd1, 5'd2, 5'd20, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h204, 32'h33, 32'h44, 32'h0, 5'd3, 5'd4, 5'd21, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    step();
    check("stall_aluin1", aluin1, 32'h11);
    check("stall_rd", {27'd0, out_rd_addr}, 32'd20);
    out_ready = 1'b1;
    step();
    check("skid_to_main_aluin1", aluin1, 32'h33);
    step();
    check("bp_drained_valid", {31'd0, out_valid}, 32'd0);
    check("bp_sb_empty", sb.size(), 32'd0);

    // 4. Flush in FULL with a coincident input
    out_ready = 1'b0;
    send(32'h300, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd22, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h304, 32'h3, 32'h4, 32'h0, 5'd3, 5'd4, 5'd23, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    out_ready = 1'b1;
    send(32'h308, 32'hDEAD, 32'hBEEF, 32'h0, 5'd5, 5'd6, 5'd24, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    send(32'h30C, 32'h55, 32'h66, 32'h0, 5'd7, 5'd8, 5'd25, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0);
    drain(10);

    // 5. Writeback while stalled: main has rs1=x5, skid has rs1=x0 and imm op2 tied to x5
    out_ready = 1'b0;
    send(32'h400, 32'h0, 32'h9, 32'h0, 5'd5, 5'd9, 5'd26, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h404, 32'h0, 32'h0, 32'h777, 5'd0, 5'd5, 5'd27, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    wb_we = 1'b1; wb_rd_addr = 5'd0; wb_data = 32'hDEADBEEF;
    step();
    check("wb_x0_aluin1", aluin1, 32'h0);
    wb_rd_addr = 5'd5; wb_data = 32'h80000015;
    step();
    wb_we = 1'b0;
`ifdef ALU_OPERAND_FWD_EN
    check("fwd_aluin1", aluin1, 32'h80000015);
    sb[0].a1 = 32'h80000015;
`else
    check("nofwd_aluin1", aluin1, 32'h0);
`endif
    check("fwd_aluin2_untouched", aluin2, 32'h9);
    drain(10);

    // 6. Async reset during FULL, then 1-cycle latency after release
    out_ready = 1'b0;
    send(32'h500, 32'hA1, 32'hA2, 32'h0, 5'd1, 5'd2, 5'd28, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
    send(32'h504, 32'hB1, 32'hB2, 32'h0, 5'd3, 5'd4, 5'd29, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_aluin1", aluin1, 32'd0);
    check("arst_funct", {28'd0, funct_alu}, 32'd0);
    step();
    #2;
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    send(32'h600, 32'hC1, 32'hC2, 32'h0, 5'd1, 5'd2, 5'd30, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_latency", {31'd0, out_valid}, 32'd1);
    drain(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

`default_nettype wire
